// File: rtl/axil_pkg.sv
// Shared types for the AXI-Lite register slave write path.
//   resp_t     : AXI write response codes driven on the B channel
//   wr_state_t : write engine FSM states
package axil_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_WRITE,
        WR_RESP
    } wr_state_t;

endpackage

// File: rtl/axil_reg_bank.sv
// Register storage for the write engine: decodes the held write address, merges
// byte-strobed data into the addressed register, flags out-of-range or read-only
// targets, and provides a combinational read port.
// Ports:
//   clk, reset_n   : clock, synchronous active-low reset
//   wr_en          : commit the held write this cycle
//   wr_addr        : byte address of the write
//   wr_data/wr_strb: write data and byte strobes
//   wr_resp_c      : response the write would earn (combinational)
//   rd_index       : read-port register index
//   rd_data        : regs[rd_index], 0 when out of range (combinational)
//   regs_q         : all registers, register i at [i*DataWidth +: DataWidth]
//   wr_pulse       : one-cycle pulse on register i the cycle after its commit
module axil_reg_bank
    import axil_pkg::*;
#(
    parameter int unsigned       AddrWidth    = 12,
    parameter int unsigned       DataWidth    = 32,
    parameter int unsigned       NumRegs      = 16,
    parameter logic [NumRegs-1:0] ReadOnlyMask = '0,
    localparam int unsigned      StrbWidth    = DataWidth / 8,
    localparam int unsigned      RegIdxW      = $clog2(NumRegs)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         wr_en,
    input  logic [AddrWidth-1:0]         wr_addr,
    input  logic [DataWidth-1:0]         wr_data,
    input  logic [StrbWidth-1:0]         wr_strb,
    output resp_t                        wr_resp_c,
    input  logic [RegIdxW-1:0]           rd_index,
    output logic [DataWidth-1:0]         rd_data,
    output logic [NumRegs*DataWidth-1:0] regs_q,
    output logic [NumRegs-1:0]           wr_pulse
);

    localparam int unsigned IdxLo = $clog2(StrbWidth);
    localparam int unsigned IdxW  = AddrWidth - IdxLo;

    logic [DataWidth-1:0] mem_q [NumRegs];
    logic [DataWidth-1:0] mem_d [NumRegs];
    logic [NumRegs-1:0]   wr_pulse_q;
    logic [NumRegs-1:0]   wr_pulse_d;
    logic [IdxW-1:0]      idx_c;
    logic                 in_range_c;

    // Word index; byte-offset bits of the address are ignored.
    assign idx_c      = wr_addr[AddrWidth-1:IdxLo];
    assign in_range_c = (idx_c < IdxW'(NumRegs));

    // Target decode, response and strobe merge.
    always_comb begin
        mem_d      = mem_q;
        wr_pulse_d = '0;
        wr_resp_c  = RESP_SLVERR;
        for (int i = 0; i < NumRegs; i++) begin
            if (in_range_c && (idx_c[RegIdxW-1:0] == RegIdxW'(i)) && !ReadOnlyMask[i]) begin
                wr_resp_c = RESP_OKAY;
                if (wr_en) begin
                    // Pulse fires even for an all-zero strobe.
                    wr_pulse_d[i] = 1'b1;
                    for (int b = 0; b < StrbWidth; b++) begin
                        if (wr_strb[b]) begin
                            mem_d[i][b*8 +: 8] = wr_data[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Storage and pulse registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                mem_q[i] <= '0;
            end
            wr_pulse_q <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    // Read mux; indices past the bank read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NumRegs; i++) begin
            if (rd_index == RegIdxW'(i)) begin
                rd_data = mem_q[i];
            end
        end
    end

    // Flattened register view.
    always_comb begin
        regs_q = '0;
        for (int i = 0; i < NumRegs; i++) begin
            regs_q[i*DataWidth +: DataWidth] = mem_q[i];
        end
    end

    assign wr_pulse = wr_pulse_q;

endmodule

// File: rtl/axil_write_engine.sv
// AXI-Lite write-path engine: joins one AW and one W FIFO entry, commits the
// strobed write into the register bank, then pushes one B response.
// Ports:
//   clk, reset_n             : clock, synchronous active-low reset
//   aw_addr/aw_empty/aw_pop  : AW FIFO head, empty flag, pop (combinational)
//   w_data/w_strb/w_empty/w_pop : W FIFO head, empty flag, pop (combinational)
//   b_resp/b_full/b_push     : B FIFO push data (registered), full flag, push (combinational)
//   rd_index/rd_data         : combinational register read port
//   regs_q                   : all registers flattened
//   wr_pulse                 : per-register commit pulse
module axil_write_engine
    import axil_pkg::*;
#(
    parameter int unsigned        AddrWidth    = 12,
    parameter int unsigned        DataWidth    = 32,
    parameter int unsigned        NumRegs      = 16,
    parameter logic [NumRegs-1:0] ReadOnlyMask = '0,
    localparam int unsigned       StrbWidth    = DataWidth / 8,
    localparam int unsigned       RegIdxW      = $clog2(NumRegs)
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [AddrWidth-1:0]         aw_addr,
    input  logic                         aw_empty,
    output logic                         aw_pop,
    input  logic [DataWidth-1:0]         w_data,
    input  logic [StrbWidth-1:0]         w_strb,
    input  logic                         w_empty,
    output logic                         w_pop,
    output logic [1:0]                   b_resp,
    input  logic                         b_full,
    output logic                         b_push,
    input  logic [RegIdxW-1:0]           rd_index,
    output logic [DataWidth-1:0]         rd_data,
    output logic [NumRegs*DataWidth-1:0] regs_q,
    output logic [NumRegs-1:0]           wr_pulse
);

    wr_state_t            state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic [StrbWidth-1:0] strb_q, strb_d;
    resp_t                b_resp_q, b_resp_d;
    resp_t                wr_resp_c;
    logic                 take_c;

    // Next-state and hold-register logic.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        strb_d   = strb_q;
        b_resp_d = b_resp_q;
        take_c   = 1'b0;
        case (state_q)
            WR_IDLE: begin
                // Both channels are consumed together or not at all.
                if (!aw_empty && !w_empty) begin
                    take_c  = 1'b1;
                    addr_d  = aw_addr;
                    data_d  = w_data;
                    strb_d  = w_strb;
                    state_d = WR_WRITE;
                end
            end
            WR_WRITE: begin
                b_resp_d = wr_resp_c;
                state_d  = WR_RESP;
            end
            WR_RESP: begin
                if (!b_full) begin
                    state_d = WR_IDLE;
                end
            end
            default: state_d = WR_IDLE;
        endcase
    end

    // State and hold registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= WR_IDLE;
            addr_q   <= '0;
            data_q   <= '0;
            strb_q   <= '0;
            b_resp_q <= RESP_OKAY;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            strb_q   <= strb_d;
            b_resp_q <= b_resp_d;
        end
    end

    // Handshakes are suppressed while reset is held.
    assign aw_pop = reset_n && take_c;
    assign w_pop  = reset_n && take_c;
    assign b_push = reset_n && (state_q == WR_RESP) && !b_full;
    assign b_resp = b_resp_q;

    axil_reg_bank #(
        .AddrWidth    (AddrWidth),
        .DataWidth    (DataWidth),
        .NumRegs      (NumRegs),
        .ReadOnlyMask (ReadOnlyMask)
    ) u_reg_bank (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (state_q == WR_WRITE),
        .wr_addr   (addr_q),
        .wr_data   (data_q),
        .wr_strb   (strb_q),
        .wr_resp_c (wr_resp_c),
        .rd_index  (rd_index),
        .rd_data   (rd_data),
        .regs_q    (regs_q),
        .wr_pulse  (wr_pulse)
    );

endmodule

// File: tb/tb_axil_write_engine.sv
// Directed and randomized bench for axil_write_engine with a register-array model.
module tb_axil_write_engine;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 32;
    localparam int unsigned NR = 16;
    localparam int unsigned SW = DW / 8;
    localparam logic [NR-1:0] RO = 16'h0008;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [AW-1:0]   aw_addr;
    logic            aw_empty;
    logic            aw_pop;
    logic [DW-1:0]   w_data;
    logic [SW-1:0]   w_strb;
    logic            w_empty;
    logic            w_pop;
    logic [1:0]      b_resp;
    logic            b_full;
    logic            b_push;
    logic [3:0]      rd_index;
    logic [DW-1:0]   rd_data;
    logic [NR*DW-1:0] regs_q;
    logic [NR-1:0]   wr_pulse;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] mdl [NR];

    always #5 clk = ~clk;

    axil_write_engine #(
        .AddrWidth    (AW),
        .DataWidth    (DW),
        .NumRegs      (NR),
        .ReadOnlyMask (RO)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .aw_addr  (aw_addr),
        .aw_empty (aw_empty),
        .aw_pop   (aw_pop),
        .w_data   (w_data),
        .w_strb   (w_strb),
        .w_empty  (w_empty),
        .w_pop    (w_pop),
        .b_resp   (b_resp),
        .b_full   (b_full),
        .b_push   (b_push),
        .rd_index (rd_index),
        .rd_data  (rd_data),
        .regs_q   (regs_q),
        .wr_pulse (wr_pulse)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] mdl_flat();
        logic [511:0] f = '0;
        for (int i = 0; i < NR; i++) f[i*DW +: DW] = mdl[i];
        return f;
    endfunction

    // Response rule: word index past the bank or a read-only register is an error.
    function automatic logic [1:0] exp_resp(input logic [AW-1:0] addr);
        int unsigned idx = 32'(addr) / 4;
        if (idx >= NR) return 2'b10;
        if (RO[idx]) return 2'b10;
        return 2'b00;
    endfunction

    // One full transaction: W arrives after w_delay idle cycles, B is full for
    // bfull_cycles cycles of the response phase.
    task automatic txn(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                       input logic [SW-1:0] strb, input int w_delay, input int bfull_cycles);
        int unsigned idx = 32'(addr) / 4;
        int unsigned ri  = idx % NR;
        logic [1:0]  er  = exp_resp(addr);
        logic [NR-1:0] ep = '0;
        @(negedge clk);
        aw_addr  = addr;
        aw_empty = 1'b0;
        w_data   = data;
        w_strb   = strb;
        w_empty  = (w_delay > 0);
        rd_index = 4'(ri);
        for (int k = 0; k < w_delay; k++) begin
            #1;
            check("wait_aw_pop", aw_pop, 0);
            check("wait_w_pop", w_pop, 0);
            @(negedge clk);
        end
        w_empty = 1'b0;
        #1;
        check("aw_pop", aw_pop, 1);
        check("w_pop", w_pop, 1);
        @(negedge clk);
        aw_empty = 1'b1;
        w_empty  = 1'b1;
        b_full   = (bfull_cycles > 0);
        #1;
        check("write_aw_pop", aw_pop, 0);
        check("write_b_push", b_push, 0);
        check("write_pulse", wr_pulse, 0);
        check("rd_old", rd_data, mdl[ri]);
        if (er == 2'b00) begin
            for (int b = 0; b < SW; b++)
                if (strb[b]) mdl[idx][b*8 +: 8] = data[b*8 +: 8];
            ep[idx] = 1'b1;
        end
        @(negedge clk);
        #1;
        check("resp_pulse", wr_pulse, ep);
        check("resp_code", b_resp, er);
        check("regs", regs_q, mdl_flat());
        check("rd_new", rd_data, mdl[ri]);
        check("resp_push", b_push, (bfull_cycles == 0));
        for (int k = 1; k < bfull_cycles; k++) begin
            @(negedge clk);
            aw_empty = 1'b0;
            w_empty  = 1'b0;
            #1;
            check("stall_push", b_push, 0);
            check("stall_aw_pop", aw_pop, 0);
            check("stall_w_pop", w_pop, 0);
            check("stall_resp", b_resp, er);
            check("stall_pulse", wr_pulse, 0);
        end
        if (bfull_cycles > 0) begin
            @(negedge clk);
            b_full   = 1'b0;
            aw_empty = 1'b1;
            w_empty  = 1'b1;
            #1;
            check("release_push", b_push, 1);
            check("release_resp", b_resp, er);
            check("release_aw_pop", aw_pop, 0);
        end
        @(negedge clk);
        #1;
        check("idle_push", b_push, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        reset_n  = 1'b0;
        aw_addr  = '0;
        aw_empty = 1'b0;
        w_data   = '0;
        w_strb   = '0;
        w_empty  = 1'b0;
        b_full   = 1'b0;
        rd_index = '0;

        // Reset: handshakes forced low even with both FIFOs non-empty.
        @(negedge clk);
        #1;
        check("rst_aw_pop", aw_pop, 0);
        check("rst_w_pop", w_pop, 0);
        check("rst_b_push", b_push, 0);
        @(negedge clk);
        #1;
        check("rst_regs", regs_q, 0);
        check("rst_pulse", wr_pulse, 0);
        check("rst_resp", b_resp, 0);
        aw_empty = 1'b1;
        w_empty  = 1'b1;
        reset_n  = 1'b1;

        // Basic full write.
        txn(12'h008, 32'hDEADBEEF, 4'hF, 0, 0);
        check("t1_reg2", regs_q[2*DW +: DW], 32'hDEADBEEF);
        // Strobe merge.
        txn(12'h004, 32'h11223344, 4'hF, 0, 0);
        txn(12'h004, 32'hAABBCCDD, 4'b0101, 0, 0);
        check("t2_reg1", regs_q[1*DW +: DW], 32'h11BB33DD);
        // Out of range and read-only.
        txn(12'h040, 32'h12345678, 4'hF, 0, 0);
        txn(12'h00C, 32'h87654321, 4'hF, 0, 0);
        check("t3_reg3", regs_q[3*DW +: DW], 0);
        // Low offset bits ignored, W late, B stall, zero strobe.
        txn(12'h013, 32'hCAFEF00D, 4'hF, 5, 0);
        txn(12'h014, 32'h0BADC0DE, 4'hF, 0, 4);
        txn(12'h008, 32'hFFFFFFFF, 4'h0, 0, 0);
        check("t_zero_strb", regs_q[2*DW +: DW], 32'hDEADBEEF);
        txn(12'hFFC, 32'h5A5A5A5A, 4'hF, 0, 1);

        // Randomized traffic.
        for (int n = 0; n < 30; n++) begin
            txn(AW'($urandom_range(0, 12'h05F)), $urandom(), SW'($urandom()),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        end

        // Reset while in the response phase discards the push.
        @(negedge clk);
        aw_addr  = 12'h020;
        w_data   = 32'h01020304;
        w_strb   = 4'hF;
        aw_empty = 1'b0;
        w_empty  = 1'b0;
        b_full   = 1'b1;
        @(negedge clk);
        aw_empty = 1'b1;
        w_empty  = 1'b1;
        @(negedge clk);
        #1;
        check("r6_in_resp_push", b_push, 0);
        check("r6_pulse", wr_pulse, 16'h0100);
        b_full  = 1'b0;
        reset_n = 1'b0;
        #1;
        check("r6_forced_push", b_push, 0);
        @(negedge clk);
        #1;
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        check("r6_regs", regs_q, mdl_flat());
        check("r6_pulse_clr", wr_pulse, 0);
        check("r6_resp_clr", b_resp, 0);
        check("r6_push_rst", b_push, 0);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        check("r6_idle_push", b_push, 0);
        check("r6_idle_pop", aw_pop, 0);
        txn(12'h020, 32'h0F0F0F0F, 4'hF, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
